ahb_mem_slave: RTL and testbench
================================

// Module: ahb_mem_slave
// PURPOSE
//  AHB-Lite single-slave memory model; sits directly downstream of the AXI-to-AHB bridge and terminates its
//  AHB master port (HADDR/HWRITE/HSIZE/HBURST/HTRANS/HWDATA in; HREADY/HRESP/HRDATA out).
//  Byte-lane writes, programmable wait states, two-cycle ERROR response; closes the bridge loop in simulation/FPGA.
// PARAMETERS
//  AHB_DATA_WIDTH     64    data bus width (bits), power of 2, >=32
//  AHB_ADDRESS_WIDTH  32    address bus width
//  MEM_BYTES          4096  memory size in bytes, multiple of AHB_DATA_WIDTH/8; addresses >= MEM_BYTES are ERROR
//  WAIT_W             4     width of wait-state control
// PORTS
//  clk          in   1      clock
//  rst          in   1      synchronous reset, active-high
//  HADDR        in   AHB_ADDRESS_WIDTH  transfer address
//  HWRITE       in   1      1=write
//  HSIZE        in   3      log2 bytes per beat
//  HBURST       in   3      burst type (informational, no effect on response)
//  HTRANS       in   2      IDLE=0 BUSY=1 NONSEQ=2 SEQ=3
//  HWDATA       in   AHB_DATA_WIDTH     write data (data phase)
//  HREADY       out  1      transfer done / address phase accepted
//  HRESP        out  1      0=OKAY 1=ERROR
//  HRDATA       out  AHB_DATA_WIDTH     read data, valid when HREADY=1 in a read data phase
//  wait_cycles_i in  WAIT_W wait states for next accepted transfer, sampled with address phase
//  xfer_done_o  out  1      1-cycle pulse when an OKAY NONSEQ/SEQ data phase completes
// BEHAVIOUR
//  Reset: HREADY=1, HRESP=0, HRDATA=0, xfer_done_o=0, FSM=IDLE, data-phase regs cleared; memory array not reset.
//  Reset mid-transfer aborts it: pending write dropped, HREADY=1 the cycle after rst deasserts.
//  Address phase accepted on a clk edge where HREADY=1 and HTRANS is NONSEQ or SEQ; latch addr/write/size/wait count.
//  IDLE/BUSY with HREADY=1: no data phase, next cycle HREADY=1 HRESP=0 (zero-wait OKAY).
//  Error check at acceptance: HADDR>=MEM_BYTES, or 2^HSIZE > AHB_DATA_WIDTH/8, or HADDR mod 2^HSIZE != 0.
//  FSM states:
//   IDLE  : HREADY=1 HRESP=0. Accept OKAY xfer -> WAIT (W>0) or DATA (W=0); error -> ERR1.
//   WAIT  : HREADY=0 HRESP=0; down-counter from W; at count 1 -> DATA. Exactly W low cycles.
//   DATA  : HREADY=1 HRESP=0; write: HWDATA lanes committed at this edge; read: HRDATA valid;
//           xfer_done_o=1; new address phase may be accepted same edge (back-to-back, no bubble) -> WAIT/DATA/ERR1/IDLE.
//   ERR1  : HREADY=0 HRESP=1, one cycle, ignores wait_cycles -> ERR2.
//   ERR2  : HREADY=1 HRESP=1; address phase sampled normally (master may have switched to IDLE). No memory write.
//  Byte lanes: offset = HADDR[log2(AHB_DATA_WIDTH/8)-1:0]; write enables bytes offset..offset+2^HSIZE-1
//   (little-endian, lane k = HWDATA[8k+7:8k]); other bytes untouched. Reads return full aligned word.
//  Read-after-write: a read accepted on the same edge a write commits returns the merged new data (forwarding).
//  HRDATA holds its last value outside read data phases. Word index = HADDR / (AHB_DATA_WIDTH/8).
//  HBURST ignored; SEQ beats treated as independent transfers; BUSY inside a burst gets zero-wait OKAY.
// TESTING
//  1 W=0: write NONSEQ 0x10 HSIZE=3 0xDEADBEEF_01234567, then read 0x10 -> HRDATA=0xDEADBEEF_01234567, HREADY never 0.
//  2 Byte write 0x13 HSIZE=0 HWDATA[31:24]=0xAA, read 0x10 -> 0xDEADBEEF_AA234567; back-to-back RAW gives same.
//  3 wait_cycles_i=3 read -> HREADY=0 exactly 3 cycles, then HREADY=1 with data, xfer_done_o one pulse.
//  4 Read 0x1000 (MEM_BYTES=4096) -> cycle1 HREADY=0 HRESP=1, cycle2 HREADY=1 HRESP=1; next read 0x10 OKAY.
//  5 Halfword write 0x11 -> ERROR sequence, memory at 0x10 unchanged; HSIZE=4 at 0x0 -> ERROR.
//  6 INCR4 NONSEQ+3 SEQ, W=1, BUSY between beats 2-3 -> 1 wait per beat, BUSY zero-wait OKAY; rst mid-WAIT -> HREADY=1, no write.

Source files
------------

// File: rtl/ahb_mem_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ahb_mem_slave                                                    |
// | Brief   : AHB-Lite memory slave; byte lanes, wait states, 2-cycle ERROR.   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module ahb_mem_slave #(
  parameter int AHB_DATA_WIDTH    = 64,
  parameter int AHB_ADDRESS_WIDTH = 32,
  parameter int MEM_BYTES         = 4096,
  parameter int WAIT_W            = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [AHB_ADDRESS_WIDTH-1:0] HADDR,
  input  logic                         HWRITE,
  input  logic [2:0]                   HSIZE,
  input  logic [2:0]                   HBURST,
  input  logic [1:0]                   HTRANS,
  input  logic [AHB_DATA_WIDTH-1:0]    HWDATA,
  output logic                         HREADY,
  output logic                         HRESP,
  output logic [AHB_DATA_WIDTH-1:0]    HRDATA,
  input  logic [WAIT_W-1:0]            wait_cycles_i,
  output logic                         xfer_done_o
);

  localparam int c_lanes = AHB_DATA_WIDTH / 8;
  localparam int c_off_w = $clog2(c_lanes);
  localparam int c_words = MEM_BYTES / c_lanes;
  localparam int c_idx_w = $clog2(c_words);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  state_t                    r_state, w_next;
  logic [c_idx_w-1:0]        r_idx;
  logic [c_off_w-1:0]        r_off;
  logic                      r_write;
  logic [2:0]                r_size;
  logic [WAIT_W-1:0]         r_cnt;
  logic [AHB_DATA_WIDTH-1:0] r_mem [c_words];

  logic                      w_ready, w_accept, w_err, w_commit, w_load_rd;
  logic                      w_tgt_write;
  logic [c_idx_w-1:0]        w_tgt_idx;
  logic [c_lanes-1:0]        w_strb;
  logic [AHB_DATA_WIDTH-1:0] w_merged, w_rd_word;
  logic [AHB_ADDRESS_WIDTH-1:0] w_align_mask;
  int                        w_lo, w_len;
  logic                      w_unused;

  assign w_unused = ^HBURST;

  assign w_ready     = (r_state == S_IDLE) || (r_state == S_DATA) || (r_state == S_ERR2);
  assign w_accept    = w_ready && ((HTRANS == 2'd2) || (HTRANS == 2'd3));
  assign w_align_mask = ~({AHB_ADDRESS_WIDTH{1'b1}} << HSIZE);
  assign w_err       = (HADDR >= AHB_ADDRESS_WIDTH'(MEM_BYTES)) ||
                       (HSIZE > 3'(c_off_w)) ||
                       (|(HADDR & w_align_mask));

  assign HREADY      = w_ready;
  assign HRESP       = (r_state == S_ERR1) || (r_state == S_ERR2);
  assign xfer_done_o = (r_state == S_DATA);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_WAIT: if (r_cnt == WAIT_W'(1)) w_next = S_DATA;
      S_ERR1: w_next = S_ERR2;
      default: begin
        if (!w_accept)                     w_next = S_IDLE;
        else if (w_err)                    w_next = S_ERR1;
        else if (wait_cycles_i == '0)      w_next = S_DATA;
        else                               w_next = S_WAIT;
      end
    endcase
  end

  // Pending write lanes: offset..offset+2^size-1 of the latched word.
  always_comb begin
    w_lo   = int'(r_off);
    w_len  = 1 << r_size;
    w_strb = '0;
    for (int k = 0; k < c_lanes; k++) begin
      if ((k >= w_lo) && (k < w_lo + w_len)) w_strb[k] = 1'b1;
    end
  end

  assign w_commit = (r_state == S_DATA) && r_write && !rst;

  always_comb begin
    w_merged = r_mem[r_idx];
    for (int k = 0; k < c_lanes; k++) begin
      if (w_strb[k]) w_merged[8*k +: 8] = HWDATA[8*k +: 8];
    end
  end

  // The transfer entering DATA is either the one just accepted or the one finishing its wait.
  assign w_tgt_idx   = (r_state == S_WAIT) ? r_idx : HADDR[c_idx_w+c_off_w-1:c_off_w];
  assign w_tgt_write = (r_state == S_WAIT) ? r_write : HWRITE;
  assign w_load_rd   = (w_next == S_DATA) && !w_tgt_write;
  assign w_rd_word   = (w_commit && (w_tgt_idx == r_idx)) ? w_merged : r_mem[w_tgt_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_off   <= '0;
      r_write <= 1'b0;
      r_size  <= '0;
      r_cnt   <= '0;
      HRDATA  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_idx   <= HADDR[c_idx_w+c_off_w-1:c_off_w];
        r_off   <= HADDR[c_off_w-1:0];
        r_write <= HWRITE;
        r_size  <= HSIZE;
        r_cnt   <= wait_cycles_i;
      end else if (r_state == S_WAIT) begin
        r_cnt   <= r_cnt - WAIT_W'(1);
      end
      if (w_load_rd) HRDATA <= w_rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit) r_mem[r_idx] <= w_merged;
  end

endmodule
`default_nettype wire

// File: tb/tb_ahb_mem_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_ahb_mem_slave                                                 |
// | Brief   : Directed table-driven bench for ahb_mem_slave.                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_ahb_mem_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [1:0]  HTRANS;
  logic [63:0] HWDATA;
  logic        HREADY;
  logic        HRESP;
  logic [63:0] HRDATA;
  logic [3:0]  wait_cycles_i;
  logic        xfer_done_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ahb_mem_slave #(
    .AHB_DATA_WIDTH(64), .AHB_ADDRESS_WIDTH(32), .MEM_BYTES(4096), .WAIT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HTRANS(HTRANS), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRESP(HRESP), .HRDATA(HRDATA), .wait_cycles_i(wait_cycles_i),
    .xfer_done_o(xfer_done_o)
  );

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  sz;
    logic [63:0] wd;
    logic [3:0]  wc;
    logic        err;
    logic [63:0] exp;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single transfer from an idle bus; checks wait count, response and read data.
  task automatic xfer(input vec_t v);
    int lows;
    HADDR = v.addr; HWRITE = v.wr; HSIZE = v.sz; HTRANS = 2'd2; wait_cycles_i = v.wc;
    step();
    HTRANS = 2'd0; HWDATA = v.wd;
    if (!v.err) begin
      lows = 0;
      while (HREADY == 1'b0 && lows < 20) begin
        step();
        lows++;
      end
      chk({v.name, "_waits"}, 64'(lows), 64'(v.wc));
      chk({v.name, "_okay"}, {62'd0, HRESP, xfer_done_o}, 64'd1);
      if (!v.wr) chk({v.name, "_rdata"}, HRDATA, v.exp);
      step();
    end else begin
      chk({v.name, "_err1"}, {62'd0, HREADY, HRESP}, 64'd1);
      step();
      chk({v.name, "_err2"}, {61'd0, HREADY, HRESP, xfer_done_o}, 64'd6);
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] bd [4];
    bd[0] = 64'h1111_1111_1111_1111; bd[1] = 64'h2222_2222_2222_2222;
    bd[2] = 64'h3333_3333_3333_3333; bd[3] = 64'h4444_4444_4444_4444;

    vt.push_back('{"w_full",   32'h010, 1, 3'd3, 64'hDEADBEEF_01234567, 4'd0, 0, 64'h0});
    vt.push_back('{"r_full",   32'h010, 0, 3'd3, 64'h0, 4'd0, 0, 64'hDEADBEEF_01234567});
    vt.push_back('{"w_byte",   32'h013, 1, 3'd0, 64'h00000000_AA000000, 4'd0, 0, 64'h0});
    vt.push_back('{"r_byte",   32'h010, 0, 3'd3, 64'h0, 4'd0, 0, 64'hDEADBEEF_AA234567});
    vt.push_back('{"r_wait3",  32'h010, 0, 3'd3, 64'h0, 4'd3, 0, 64'hDEADBEEF_AA234567});
    vt.push_back('{"r_oob",    32'h1000, 0, 3'd3, 64'h0, 4'd2, 1, 64'h0});
    vt.push_back('{"r_after",  32'h010, 0, 3'd3, 64'h0, 4'd0, 0, 64'hDEADBEEF_AA234567});
    vt.push_back('{"w_mis_h",  32'h011, 1, 3'd1, 64'hFFFFFFFF_FFFFFFFF, 4'd0, 1, 64'h0});
    vt.push_back('{"r_unchg",  32'h010, 0, 3'd3, 64'h0, 4'd0, 0, 64'hDEADBEEF_AA234567});
    vt.push_back('{"r_sz4",    32'h000, 0, 3'd4, 64'h0, 4'd0, 1, 64'h0});
    vt.push_back('{"r_mis_w",  32'h012, 0, 3'd2, 64'h0, 4'd0, 1, 64'h0});
    vt.push_back('{"w_half",   32'h016, 1, 3'd1, 64'hCAFE0000_00000000, 4'd2, 0, 64'h0});
    vt.push_back('{"r_half",   32'h010, 0, 3'd3, 64'h0, 4'd1, 0, 64'hCAFEBEEF_AA234567});
    vt.push_back('{"w_zero",   32'h020, 1, 3'd3, 64'h0, 4'd1, 0, 64'h0});
    vt.push_back('{"w_word",   32'h024, 1, 3'd2, 64'h11223344_55667788, 4'd0, 0, 64'h0});
    vt.push_back('{"r_word",   32'h020, 0, 3'd3, 64'h0, 4'd0, 0, 64'h11223344_00000000});
    vt.push_back('{"w_last",   32'hFF8, 1, 3'd3, 64'h01234567_89ABCDEF, 4'd0, 0, 64'h0});
    vt.push_back('{"r_lastb",  32'hFFF, 0, 3'd0, 64'h0, 4'd0, 0, 64'h01234567_89ABCDEF});

    rst = 1'b1; HADDR = '0; HWRITE = 1'b0; HSIZE = '0; HBURST = '0; HTRANS = 2'd0;
    HWDATA = '0; wait_cycles_i = '0;
    repeat (3) step();
    rst = 1'b0;
    chk("reset_out", {HRDATA[0], HREADY, HRESP, xfer_done_o}, 64'h4);
    chk("reset_rdata", HRDATA, 64'h0);
    step();
    chk("idle_okay", {62'd0, HREADY, HRESP}, 64'h2);

    foreach (vt[i]) xfer(vt[i]);

    // Read accepted on the edge the byte write commits must see the merged word.
    HADDR = 32'h013; HWRITE = 1'b1; HSIZE = 3'd0; HTRANS = 2'd2; wait_cycles_i = 4'd0;
    step();
    HWDATA = 64'h00000000_55000000;
    HADDR = 32'h010; HWRITE = 1'b0; HSIZE = 3'd3; HTRANS = 2'd2;
    chk("raw_wdata_phase", {62'd0, HREADY, xfer_done_o}, 64'h3);
    step();
    HTRANS = 2'd0;
    chk("raw_rd_phase", {62'd0, HREADY, xfer_done_o}, 64'h3);
    chk("raw_fwd", HRDATA, 64'hCAFEBEEF_55234567);
    step();
    chk("hrdata_hold", HRDATA, 64'hCAFEBEEF_55234567);

    // INCR4 write burst with one wait per beat and a BUSY between beats 2 and 3.
    HADDR = 32'h030; HWRITE = 1'b1; HSIZE = 3'd3; HBURST = 3'd3; HTRANS = 2'd2;
    wait_cycles_i = 4'd1;
    for (int i = 0; i < 4; i++) begin
      step();
      HWDATA = bd[i];
      chk("burst_wait", {62'd0, HREADY, HRESP}, 64'h0);
      step();
      chk("burst_data", {61'd0, HREADY, HRESP, xfer_done_o}, 64'h5);
      if (i == 1) begin
        HTRANS = 2'd1; HADDR = 32'h040;
        step();
        chk("busy_okay", {61'd0, HREADY, HRESP, xfer_done_o}, 64'h4);
      end
      if (i < 3) begin
        HTRANS = 2'd3; HADDR = 32'h030 + 32'(8 * (i + 1));
      end else begin
        HTRANS = 2'd0;
      end
    end
    step();
    HBURST = 3'd0;
    xfer('{"r_beat0", 32'h030, 0, 3'd3, 64'h0, 4'd0, 0, 64'h1111_1111_1111_1111});
    xfer('{"r_beat2", 32'h040, 0, 3'd3, 64'h0, 4'd0, 0, 64'h3333_3333_3333_3333});
    xfer('{"r_beat3", 32'h048, 0, 3'd3, 64'h0, 4'd0, 0, 64'h4444_4444_4444_4444});

    // Reset during a wait state drops the write.
    HADDR = 32'h010; HWRITE = 1'b1; HSIZE = 3'd3; HTRANS = 2'd2; wait_cycles_i = 4'd3;
    step();
    HTRANS = 2'd0; HWDATA = 64'hFFFF_FFFF_FFFF_FFFF;
    chk("rst_pre_wait", {63'd0, HREADY}, 64'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_out", {61'd0, HREADY, HRESP, xfer_done_o}, 64'h4);
    chk("rst_mid_rdata", HRDATA, 64'h0);
    step();
    chk("rst_after_idle", {61'd0, HREADY, HRESP, xfer_done_o}, 64'h4);
    xfer('{"r_post_rst", 32'h010, 0, 3'd3, 64'h0, 4'd0, 0, 64'hCAFEBEEF_55234567});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
